// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Stall / flush / freeze controller for a five-stage in-order pipeline.
// A small FSM (RUN, MWAIT, HALT) tracks outstanding data-memory accesses.
// It raises a sticky "halted" error when memory fails to answer within
// MEM_TIMEOUT consecutive frozen cycles in MWAIT.
// All pipeline control outputs are combinational from the current state and
// inputs. Only the state, the wait counter and the halted flag are registered.
//
// Parameters
//   MEM_TIMEOUT   frozen MWAIT cycles tolerated before halting (1..255)
//
// Ports
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   load_use      load-use stall request from the hazard unit
//   branch_taken  branch resolved taken in EX
//   jump          jump decoded in ID
//   mem_req       MEM stage holds a data-memory access
//   mem_ready     data memory completes the access this cycle
//   pc_we, ifid_we, idex_we, exmem_we        pipeline register write enables
//   ifid_flush, idex_flush, memwb_flush      bubble insertion
//   halted        sticky memory-timeout error
//   state         current FSM state (00 RUN, 01 MWAIT, 10/11 HALT)
//   stall_cnt     (PIPELINE_CTRL_PERF_EN only) load-use or freeze cycles
//   flush_cnt     (PIPELINE_CTRL_PERF_EN only) cycles with ifid_flush=1
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN adds saturating performance
// counters. Without it, the counters and their ports are absent.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        halted,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MWAIT    = 2'b01,
        ST_HALT     = 2'b10,
        ST_HALT_ALT = 2'b11
    } state_t;

    // Counter value seen on the last tolerated frozen MWAIT cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_next_s;
    logic       halted_r;
    logic       halted_next_s;
    logic       halt_s;
    logic       freeze_s;
    logic       stall_s;

    // Encoding 2'b11 is never entered but is decoded as HALT for safety.
    assign halt_s   = (state_r == ST_HALT) || (state_r == ST_HALT_ALT);
    assign freeze_s = !halt_s && mem_req && !mem_ready;
    // Cycle in which the load-use stall actually wins the priority chain.
    assign stall_s  = !halt_s && !freeze_s && !branch_taken && load_use;

    assign state  = state_r;
    assign halted = halted_r;

    // Pipeline control decode: HALT > freeze > branch > load-use > jump > normal.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (halt_s) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (freeze_s) begin
            // Hold everything up to MEM; push a bubble into WB.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // A concurrent jump stays in ID and is seen again next cycle.
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else if (jump) begin
            ifid_flush = 1'b1;
        end else begin
            ifid_flush = 1'b0;
        end
    end

    // Next-state, wait-counter and sticky-halt logic.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        halted_next_s   = halted_r;
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    state_next_s    = ST_MWAIT;
                    wait_cnt_next_s = 8'd0;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_MWAIT: begin
                if (freeze_s) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_next_s  = ST_HALT;
                        halted_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_MWAIT;
                    end
                    if (wait_cnt_r != 8'hFF) begin
                        wait_cnt_next_s = wait_cnt_r + 8'd1;
                    end else begin
                        wait_cnt_next_s = 8'hFF;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT, ST_HALT_ALT: begin
                state_next_s  = ST_HALT;
                halted_next_s = 1'b1;
            end
            default: begin
                state_next_s  = ST_HALT;
                halted_next_s = 1'b1;
            end
        endcase
    end

    // State, wait counter and halted flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            halted_r   <= halted_next_s;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if ((stall_s || freeze_s) && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = stall_s;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic clk;
    logic rst_n;
    logic load_use;
    logic branch_taken;
    logic jump;
    logic mem_req;
    logic mem_ready;

    logic       pc_we, ifid_we, idex_we, exmem_we;
    logic       ifid_flush, idex_flush, memwb_flush, halted;
    logic [1:0] state;
    logic       t_pc_we, t_ifid_we, t_idex_we, t_exmem_we;
    logic       t_ifid_flush, t_idex_flush, t_memwb_flush, t_halted;
    logic [1:0] t_state;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt, t_stall_cnt, t_flush_cnt;
`endif

    logic [6:0] outs;
    logic [6:0] t_outs;
    assign outs   = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush};
    assign t_outs = {t_pc_we, t_ifid_we, t_idex_we, t_exmem_we, t_ifid_flush, t_idex_flush, t_memwb_flush};

    int total;
    int bad;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
        .jump(jump), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .halted(halted),
`ifdef PIPELINE_CTRL_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state(state)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
        .jump(jump), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(t_pc_we), .ifid_we(t_ifid_we), .idex_we(t_idex_we), .exmem_we(t_exmem_we),
        .ifid_flush(t_ifid_flush), .idex_flush(t_idex_flush), .memwb_flush(t_memwb_flush),
        .halted(t_halted),
`ifdef PIPELINE_CTRL_PERF_EN
        .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt),
`endif
        .state(t_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a new input vector at the falling edge; outputs settle 1 time unit later.
    task automatic step(input logic lu, input logic bt, input logic j,
                        input logic mr, input logic mrdy);
        @(negedge clk);
        load_use = lu; branch_taken = bt; jump = j; mem_req = mr; mem_ready = mrdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        load_use = 1'b0; branch_taken = 1'b0; jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 2'b00 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_state got=%b/%b exp=00/0", state, halted);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (outs !== 7'b1111000 || state !== 2'b00 || halted !== 1'b0) begin
                bad++; $display("FAIL idle%0d got=%b/%b/%b exp=1111000/00/0", i, outs, state, halted);
            end
        end
    endtask

    task automatic test_load_use_jump();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (outs !== 7'b0011010) begin
            bad++; $display("FAIL load_use_jump got=%b exp=0011010", outs);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (outs !== 7'b1111100) begin
            bad++; $display("FAIL jump_after got=%b exp=1111100", outs);
        end
    endtask

    task automatic test_branch();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== 7'b1111110) begin
            bad++; $display("FAIL branch_lu got=%b exp=1111110", outs);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPELINE_CTRL_PERF_EN
        total++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
            bad++; $display("FAIL branch_cnts got=%0d/%0d exp=0/1", stall_cnt, flush_cnt);
        end
`endif
        // Freeze must override a taken branch and a jump.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (outs !== 7'b0000001) begin
            bad++; $display("FAIL freeze_prio got=%b exp=0000001", outs);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            total++;
            if (outs !== 7'b0000001 || state !== ((i == 1) ? 2'b00 : 2'b01)) begin
                bad++; $display("FAIL mwait_c%0d got=%b/%b exp=0000001/%b", i, outs, state,
                                (i == 1) ? 2'b00 : 2'b01);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        if (outs !== 7'b1111000 || state !== 2'b01) begin
            bad++; $display("FAIL mwait_ready got=%b/%b exp=1111000/01", outs, state);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (state !== 2'b00 || halted !== 1'b0) begin
            bad++; $display("FAIL mwait_exit got=%b/%b exp=00/0", state, halted);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            total++;
            if (t_halted !== 1'b0 || t_outs !== 7'b0000001) begin
                bad++; $display("FAIL timeout_c%0d got=%b/%b exp=0/0000001", i, t_halted, t_outs);
            end
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (t_state !== 2'b10 || t_halted !== 1'b1 || t_outs !== 7'b0000000) begin
            bad++; $display("FAIL timeout_halt got=%b/%b/%b exp=10/1/0000000", t_state, t_halted, t_outs);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (t_state !== 2'b10 || t_halted !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky got=%b/%b exp=10/1", t_state, t_halted);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (t_state !== 2'b00 || t_halted !== 1'b0) begin
            bad++; $display("FAIL timeout_reset got=%b/%b exp=00/0", t_state, t_halted);
        end
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (t_outs !== 7'b1111000 || t_state !== 2'b00) begin
            bad++; $display("FAIL timeout_after got=%b/%b exp=1111000/00", t_outs, t_state);
        end
    endtask

    task automatic test_async_reset_mwait();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL async_pre got=%b exp=01", state);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 2'b00 || halted !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%b/%b exp=00/0", state, halted);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++; $display("FAIL async_stall_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        mem_req = 1'b0;
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== 7'b0011010 || state !== 2'b00) begin
            bad++; $display("FAIL async_after got=%b/%b exp=0011010/00", outs, state);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        load_use = 1'b0; branch_taken = 1'b0; jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_load_use_jump();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset_mwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
